// File: rtl/mfp_ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: MIPS core (M0) and SREC loader (M1) share one slave bus.
// Ownership changes only at transfer boundaries; data-phase ownership routes HWDATA/HREADY/HRESP.
module mfp_ahb_master_arbiter #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned DEFAULT_M = 0
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              loader_active,

   input  logic [31:0]       m0_HADDR,
   input  logic [1:0]        m0_HTRANS,
   input  logic              m0_HWRITE,
   input  logic [2:0]        m0_HSIZE,
   input  logic [2:0]        m0_HBURST,
   input  logic [3:0]        m0_HPROT,
   input  logic              m0_HMASTLOCK,
   input  logic [31:0]       m0_HWDATA,
   output logic              m0_HREADY,
   output logic              m0_HRESP,

   input  logic [31:0]       m1_HADDR,
   input  logic [1:0]        m1_HTRANS,
   input  logic              m1_HWRITE,
   input  logic [2:0]        m1_HSIZE,
   input  logic [2:0]        m1_HBURST,
   input  logic [3:0]        m1_HPROT,
   input  logic              m1_HMASTLOCK,
   input  logic [31:0]       m1_HWDATA,
   output logic              m1_HREADY,
   output logic              m1_HRESP,

   output logic [31:0]       s_HADDR,
   output logic [1:0]        s_HTRANS,
   output logic              s_HWRITE,
   output logic [2:0]        s_HSIZE,
   output logic [2:0]        s_HBURST,
   output logic [3:0]        s_HPROT,
   output logic              s_HMASTLOCK,
   output logic [31:0]       s_HWDATA,
   input  logic              s_HREADY,
   input  logic              s_HRESP,

   output logic              grant,
   output logic [CNT_W-1:0]  m1_xfer_count
);

   localparam logic DEF_M = 1'(DEFAULT_M);

   logic             grant_q,    grant_d;
   logic             dp_valid_q, dp_valid_d;
   logic             dp_owner_q, dp_owner_d;
   logic             last_q,     last_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic [1:0]       own_trans_c;
   logic             own_lock_c;
   logic             switch_c;
   logic             next_owner_c;
   logic             req0_c, req1_c;

   // Address/control mux follows the address-phase owner; write data follows the data-phase owner
   always_comb begin
      own_trans_c = grant_q ? m1_HTRANS    : m0_HTRANS;
      own_lock_c  = grant_q ? m1_HMASTLOCK : m0_HMASTLOCK;
      s_HADDR     = grant_q ? m1_HADDR     : m0_HADDR;
      s_HTRANS    = own_trans_c;
      s_HWRITE    = grant_q ? m1_HWRITE    : m0_HWRITE;
      s_HSIZE     = grant_q ? m1_HSIZE     : m0_HSIZE;
      s_HBURST    = grant_q ? m1_HBURST    : m0_HBURST;
      s_HPROT     = grant_q ? m1_HPROT     : m0_HPROT;
      s_HMASTLOCK = own_lock_c;
      s_HWDATA    = dp_owner_q ? m1_HWDATA : m0_HWDATA;
   end

   // Ready goes to the address owner, or to a non-owner still finishing its data phase
   always_comb begin
      m0_HREADY = 1'b0;
      m1_HREADY = 1'b0;
      m0_HRESP  = 1'b0;
      m1_HRESP  = 1'b0;
      if (!grant_q || (dp_valid_q && !dp_owner_q)) m0_HREADY = s_HREADY;
      if ( grant_q || (dp_valid_q &&  dp_owner_q)) m1_HREADY = s_HREADY;
      if (dp_valid_q && !dp_owner_q) m0_HRESP = s_HRESP;
      if (dp_valid_q &&  dp_owner_q) m1_HRESP = s_HRESP;
   end

   // Switch point detection and next-owner priority: loader, single requester, round-robin, default
   always_comb begin
      req0_c       = m0_HTRANS[1];
      req1_c       = m1_HTRANS[1];
      switch_c     = s_HREADY && (own_trans_c == 2'b00) && !own_lock_c;
      next_owner_c = DEF_M;
      if (loader_active && req1_c)  next_owner_c = 1'b1;
      else if (req0_c ^ req1_c)     next_owner_c = req1_c;
      else if (req0_c && req1_c)    next_owner_c = ~last_q;
   end

   // Next-state for grant, data-phase tracking, round-robin history and loader counter
   always_comb begin
      grant_d    = grant_q;
      dp_valid_d = dp_valid_q;
      dp_owner_d = dp_owner_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      if (s_HREADY) begin
         dp_valid_d = own_trans_c[1];
         dp_owner_d = grant_q;
         if (own_trans_c[1]) last_d = grant_q;
         if (grant_q && own_trans_c[1] && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
      end
      if (switch_c) grant_d = next_owner_c;
   end

   // State registers; an in-flight data phase is dropped on reset
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         grant_q    <= DEF_M;
         dp_valid_q <= 1'b0;
         dp_owner_q <= 1'b0;
         last_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         grant_q    <= grant_d;
         dp_valid_q <= dp_valid_d;
         dp_owner_q <= dp_owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
      end
   end

   assign grant         = grant_q;
   assign m1_xfer_count = cnt_q;

endmodule

// File: tb/tb_mfp_ahb_master_arbiter.sv
// Directed bench for the two-master arbiter with a cycle-level reference model.
module tb_mfp_ahb_master_arbiter;

   localparam int unsigned CNT_W = 2;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        loader_active;
   logic [31:0] m0_HADDR, m1_HADDR, m0_HWDATA, m1_HWDATA;
   logic [1:0]  m0_HTRANS, m1_HTRANS;
   logic        m0_HWRITE, m1_HWRITE, m0_HMASTLOCK, m1_HMASTLOCK;
   logic [2:0]  m0_HSIZE, m1_HSIZE, m0_HBURST, m1_HBURST;
   logic [3:0]  m0_HPROT, m1_HPROT;
   logic        m0_HREADY, m1_HREADY, m0_HRESP, m1_HRESP;
   logic [31:0] s_HADDR, s_HWDATA;
   logic [1:0]  s_HTRANS;
   logic        s_HWRITE, s_HMASTLOCK, s_HREADY, s_HRESP;
   logic [2:0]  s_HSIZE, s_HBURST;
   logic [3:0]  s_HPROT;
   logic        grant;
   logic [CNT_W-1:0] m1_xfer_count;

   int checks = 0;
   int errors = 0;

   mfp_ahb_master_arbiter #(.CNT_W(CNT_W), .DEFAULT_M(0)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .loader_active(loader_active),
      .m0_HADDR(m0_HADDR), .m0_HTRANS(m0_HTRANS), .m0_HWRITE(m0_HWRITE), .m0_HSIZE(m0_HSIZE),
      .m0_HBURST(m0_HBURST), .m0_HPROT(m0_HPROT), .m0_HMASTLOCK(m0_HMASTLOCK),
      .m0_HWDATA(m0_HWDATA), .m0_HREADY(m0_HREADY), .m0_HRESP(m0_HRESP),
      .m1_HADDR(m1_HADDR), .m1_HTRANS(m1_HTRANS), .m1_HWRITE(m1_HWRITE), .m1_HSIZE(m1_HSIZE),
      .m1_HBURST(m1_HBURST), .m1_HPROT(m1_HPROT), .m1_HMASTLOCK(m1_HMASTLOCK),
      .m1_HWDATA(m1_HWDATA), .m1_HREADY(m1_HREADY), .m1_HRESP(m1_HRESP),
      .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE), .s_HSIZE(s_HSIZE),
      .s_HBURST(s_HBURST), .s_HPROT(s_HPROT), .s_HMASTLOCK(s_HMASTLOCK), .s_HWDATA(s_HWDATA),
      .s_HREADY(s_HREADY), .s_HRESP(s_HRESP),
      .grant(grant), .m1_xfer_count(m1_xfer_count)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the address bus, who owns the pending data phase, loader tally
   int md_owner;      // address-phase owner index
   bit md_pending;    // a data phase is outstanding
   int md_dp_owner;   // its owner index
   int md_prev;       // master of most recent accepted transfer
   int md_tally;      // accepted loader transfers, clipped

   always @(posedge HCLK or negedge HRESETn) begin
      int owner_trans, owner_lock, want0, want1, pick;
      if (!HRESETn) begin
         md_owner <= 0; md_pending <= 0; md_dp_owner <= 0; md_prev <= 0; md_tally <= 0;
      end else begin
         owner_trans = (md_owner == 1) ? int'(m1_HTRANS) : int'(m0_HTRANS);
         owner_lock  = (md_owner == 1) ? int'(m1_HMASTLOCK) : int'(m0_HMASTLOCK);
         if (s_HREADY) begin
            md_pending  <= (owner_trans >= 2);
            md_dp_owner <= md_owner;
            if (owner_trans >= 2) begin
               md_prev <= md_owner;
               if (md_owner == 1 && md_tally < CNT_MAX) md_tally <= md_tally + 1;
            end
            if (owner_trans == 0 && owner_lock == 0) begin
               want0 = (m0_HTRANS >= 2) ? 1 : 0;
               want1 = (m1_HTRANS >= 2) ? 1 : 0;
               if (loader_active && want1 == 1)  pick = 1;
               else if (want0 + want1 == 1)      pick = want1;
               else if (want0 + want1 == 2)      pick = 1 - md_prev;
               else                              pick = 0;
               md_owner <= pick;
            end
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model
   always @(negedge HCLK) begin
      bit o1, d1;
      o1 = (md_owner == 1);
      d1 = (md_dp_owner == 1);
      chk("grant", 32'(grant), 32'(o1));
      chk("s_HADDR", s_HADDR, o1 ? m1_HADDR : m0_HADDR);
      chk("s_HTRANS", 32'(s_HTRANS), 32'(o1 ? m1_HTRANS : m0_HTRANS));
      chk("s_HWRITE", 32'(s_HWRITE), 32'(o1 ? m1_HWRITE : m0_HWRITE));
      chk("s_HSIZE", 32'(s_HSIZE), 32'(o1 ? m1_HSIZE : m0_HSIZE));
      chk("s_HBURST", 32'(s_HBURST), 32'(o1 ? m1_HBURST : m0_HBURST));
      chk("s_HPROT", 32'(s_HPROT), 32'(o1 ? m1_HPROT : m0_HPROT));
      chk("s_HMASTLOCK", 32'(s_HMASTLOCK), 32'(o1 ? m1_HMASTLOCK : m0_HMASTLOCK));
      chk("s_HWDATA", s_HWDATA, d1 ? m1_HWDATA : m0_HWDATA);
      chk("m0_HREADY", 32'(m0_HREADY),
          32'((!o1 || (md_pending && !d1)) ? s_HREADY : 1'b0));
      chk("m1_HREADY", 32'(m1_HREADY),
          32'((o1 || (md_pending && d1)) ? s_HREADY : 1'b0));
      chk("m0_HRESP", 32'(m0_HRESP), 32'((md_pending && !d1) ? s_HRESP : 1'b0));
      chk("m1_HRESP", 32'(m1_HRESP), 32'((md_pending && d1) ? s_HRESP : 1'b0));
      chk("m1_xfer_count", 32'(m1_xfer_count), 32'(md_tally));
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drv0(input logic [1:0] t, input logic [31:0] a);
      m0_HTRANS = t; m0_HADDR = a;
   endtask

   task automatic drv1(input logic [1:0] t, input logic [31:0] a);
      m1_HTRANS = t; m1_HADDR = a;
   endtask

   initial begin
      loader_active = 0;
      drv0(2'b00, 32'h0); drv1(2'b00, 32'h0);
      m0_HWRITE = 1; m0_HSIZE = 3'd2; m0_HBURST = 3'd0; m0_HPROT = 4'h3; m0_HMASTLOCK = 0;
      m1_HWRITE = 1; m1_HSIZE = 3'd1; m1_HBURST = 3'd0; m1_HPROT = 4'hA; m1_HMASTLOCK = 0;
      m0_HWDATA = 32'h0; m1_HWDATA = 32'hCAFE_0000;
      s_HREADY = 1; s_HRESP = 0;
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1;
      #1;

      // Reset state, both idle
      chk("t1 grant", 32'(grant), 0);
      chk("t1 s_HTRANS", 32'(s_HTRANS), 0);
      chk("t1 count", 32'(m1_xfer_count), 0);
      chk("t1 m0_HREADY", 32'(m0_HREADY), 1);
      chk("t1 m1_HREADY", 32'(m1_HREADY), 0);
      step();

      // Core single write
      drv0(2'b10, 32'hBF80_0000); #1;
      chk("t2 addr", s_HADDR, 32'hBF80_0000);
      chk("t2 m1_HREADY a", 32'(m1_HREADY), 0);
      step();
      drv0(2'b00, 32'h0); m0_HWDATA = 32'h1234; #1;
      chk("t2 wdata", s_HWDATA, 32'h1234);
      chk("t2 m1_HREADY d", 32'(m1_HREADY), 0);
      step();

      // Locked idle core keeps the bus despite a loader request
      m0_HMASTLOCK = 1; drv1(2'b10, 32'h100); #1;
      chk("lock grant a", 32'(grant), 0);
      step();
      chk("lock grant b", 32'(grant), 0);
      chk("lock m1_HREADY", 32'(m1_HREADY), 0);
      m0_HMASTLOCK = 0; drv1(2'b00, 32'h100);
      step();

      // Loader priority waits for the core's INCR4 to finish
      loader_active = 1; drv1(2'b10, 32'h100); m0_HBURST = 3'd3;
      for (int i = 0; i < 4; i++) begin
         drv0((i == 0) ? 2'b10 : 2'b11, 32'(i * 4)); #1;
         chk("t3 burst grant", 32'(grant), 0);
         chk("t3 burst addr", s_HADDR, 32'(i * 4));
         chk("t3 burst m1_HREADY", 32'(m1_HREADY), 0);
         step();
      end
      drv0(2'b00, 32'h0); m0_HBURST = 3'd0; #1;
      chk("t3 idle grant", 32'(grant), 0);
      step();
      chk("t3 switched grant", 32'(grant), 1);
      chk("t3 m1 addr", s_HADDR, 32'h100);
      chk("t3 m1_HREADY", 32'(m1_HREADY), 1);
      chk("t3 m0_HREADY", 32'(m0_HREADY), 0);
      step();

      // Round-robin alternation with both masters requesting
      loader_active = 0; drv1(2'b00, 32'h0); drv0(2'b10, 32'h200); #1;
      chk("t3 count", 32'(m1_xfer_count), 1);
      chk("t4 g1", 32'(grant), 1);
      step();
      drv1(2'b10, 32'h300); #1;
      chk("t4 g0", 32'(grant), 0);
      chk("t4 a200", s_HADDR, 32'h200);
      step();
      drv0(2'b00, 32'h0); #1;
      chk("t4 g0 idle", 32'(grant), 0);
      step();
      drv0(2'b10, 32'h204); #1;
      chk("t4 g1 b", 32'(grant), 1);
      chk("t4 a300", s_HADDR, 32'h300);
      step();
      drv1(2'b00, 32'h0); #1;
      chk("t4 g1 idle", 32'(grant), 1);
      step();
      drv1(2'b10, 32'h304); #1;
      chk("t4 g0 b", 32'(grant), 0);
      chk("t4 a204", s_HADDR, 32'h204);
      step();
      drv0(2'b00, 32'h0); #1;
      step();
      chk("t4 g1 c", 32'(grant), 1);
      chk("t4 a304", s_HADDR, 32'h304);
      chk("t4 count", 32'(m1_xfer_count), 2);
      step();

      // Wait states in the loader's last data phase, core stalled meanwhile
      drv1(2'b00, 32'h0); drv0(2'b10, 32'h208); s_HREADY = 0;
      for (int w = 0; w < 2; w++) begin
         #1;
         chk("t5 wait grant", 32'(grant), 1);
         chk("t5 wait m1_HREADY", 32'(m1_HREADY), 0);
         chk("t5 wait m0_HREADY", 32'(m0_HREADY), 0);
         chk("t5 saturated count", 32'(m1_xfer_count), 3);
         step();
      end
      s_HREADY = 1; #1;
      chk("t5 done grant", 32'(grant), 1);
      chk("t5 done m1_HREADY", 32'(m1_HREADY), 1);
      chk("t5 done m0_HREADY", 32'(m0_HREADY), 0);
      step();
      chk("t5 core grant", 32'(grant), 0);
      chk("t5 core addr", s_HADDR, 32'h208);
      chk("t5 core m0_HREADY", 32'(m0_HREADY), 1);
      step();

      // Two-cycle ERROR on a loader data phase
      drv0(2'b00, 32'h0); drv1(2'b10, 32'h400); loader_active = 1; #1;
      step();
      chk("t6 grant", 32'(grant), 1);
      chk("t6 addr", s_HADDR, 32'h400);
      step();
      drv1(2'b00, 32'h0); s_HREADY = 0; s_HRESP = 1; #1;
      chk("t6 err1 m1_HRESP", 32'(m1_HRESP), 1);
      chk("t6 err1 m0_HRESP", 32'(m0_HRESP), 0);
      chk("t6 err1 m1_HREADY", 32'(m1_HREADY), 0);
      step();
      s_HREADY = 1; #1;
      chk("t6 err2 m1_HRESP", 32'(m1_HRESP), 1);
      chk("t6 err2 m0_HRESP", 32'(m0_HRESP), 0);
      chk("t6 err2 m1_HREADY", 32'(m1_HREADY), 1);
      step();
      s_HRESP = 0; drv1(2'b10, 32'h600); #1;
      chk("t6 default grant", 32'(grant), 0);
      chk("t6 m1_HRESP clear", 32'(m1_HRESP), 0);
      step();
      chk("t6 reload grant", 32'(grant), 1);
      chk("t6 reload addr", s_HADDR, 32'h600);
      step();

      // Asynchronous reset in the middle of a loader data phase
      drv1(2'b00, 32'h0); #1;
      chk("rst pre grant", 32'(grant), 1);
      chk("rst pre count", 32'(m1_xfer_count), 3);
      chk("rst pre wdata", s_HWDATA, 32'hCAFE_0000);
      HRESETn = 0; #1;
      chk("rst grant", 32'(grant), 0);
      chk("rst count", 32'(m1_xfer_count), 0);
      chk("rst m0_HREADY", 32'(m0_HREADY), 1);
      chk("rst m1_HREADY", 32'(m1_HREADY), 0);
      chk("rst s_HTRANS", 32'(s_HTRANS), 0);
      chk("rst wdata", s_HWDATA, 32'h1234);
      step();
      step();
      HRESETn = 1;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
